// File: rtl/seq_1010.sv
// seq_1010 -- Moore detector for the serial pattern 1-0-1-0, non-overlapping.
//
// One input bit is sampled on each rising clock edge. After the fourth bit of
// a complete pattern, the detector raises z for one cycle. After a detection,
// none of the matched bits are reused, so "10101010" detects after bits 4 and
// 8 only.
//
// Ports:
//   clk : system clock, rising-edge only
//   rst : synchronous, active-high reset; forces the idle state and z=0
//   x   : serial data bit, sampled on each rising edge of clk
//   z   : detect flag, high for exactly the one cycle spent in DETECT
module seq_1010 (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "101"
    S4 = 3'd4   // "1010" complete (DETECT)
  } state_t;

  state_t state;
  state_t next;

  always_comb begin
    next = S0;
    unique case (state)
      S0:      next = x ? S1 : S0;
      S1:      next = x ? S1 : S2;
      S2:      next = x ? S3 : S0;
      S3:      next = x ? S1 : S4;
      // Non-overlapping: a '1' after DETECT starts a fresh match rather than
      // reusing the trailing "10".
      S4:      next = x ? S1 : S0;
      // The unused codes 5..7 recover to idle, so the FSM cannot lock up.
      default: next = S0;
    endcase
  end

  // z is registered together with the state. It equals (state == S4) on every
  // cycle, so there is no combinational path from x to z.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      z     <= 1'b0;
    end else begin
      state <= next;
      z     <= (next == S4);
    end
  end

endmodule

// File: tb/tb_seq_1010.sv
// tb_seq_1010 -- self-checking bench for seq_1010.
//
// Expected z values are pushed to a scoreboard queue when stimulus is driven.
// They are popped and compared 1 ns after the clock edge that produces them.
// The bench runs three phases:
//   1. an absolute-time stream (10 ns clock, reset released at 12 ns, x
//      changed 4 ns after each edge);
//   2. a table of {rst, x, expected z} vectors for the directed cases;
//   3. a random stream checked against a history-based reference model.
module tb_seq_1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic z;

  seq_1010 dut (
    .clk(clk),
    .rst(rst),
    .x  (x),
    .z  (z)
  );

  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  bit          exp_q[$];

  typedef struct {
    bit    r;
    bit    xv;
    bit    ez;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name);
    bit e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: z=%0b but scoreboard empty", name, z);
    end else begin
      e = exp_q.pop_front();
      if (z !== e) begin
        mismatched++;
        $display("FAIL %s: z=%0b expected %0b", name, z, e);
      end
    end
  endtask

  task automatic apply(input bit r, input bit xv, input bit ez, input string name);
    rst = r;
    x   = xv;
    exp_q.push_back(ez);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic add(input bit r, input bit xv, input bit ez, input string name);
    vec_t v;
    v.r    = r;
    v.xv   = xv;
    v.ez   = ez;
    v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    bit       ts[12];
    bit [3:0] hist;
    int       cnt;
    bit       r;
    bit       xv;
    bit       ez;

    // Directed vectors: {rst, x, expected z after the edge}.
    add(1, 0, 0, "reset_x0");
    add(1, 1, 0, "reset_x1_ignored");
    add(0, 0, 0, "idle_0");
    // single pattern
    add(0, 1, 0, "single_b1");
    add(0, 0, 0, "single_b2");
    add(0, 1, 0, "single_b3");
    add(0, 0, 1, "single_detect");
    add(0, 0, 0, "single_fall");
    // non-overlap: 10101010
    add(0, 1, 0, "novl_b1");
    add(0, 0, 0, "novl_b2");
    add(0, 1, 0, "novl_b3");
    add(0, 0, 1, "novl_b4_detect");
    add(0, 1, 0, "novl_b5");
    add(0, 0, 0, "novl_b6_nodetect");
    add(0, 1, 0, "novl_b7");
    add(0, 0, 1, "novl_b8_detect");
    add(0, 0, 0, "novl_fall");
    // broken pattern: 101100
    add(0, 1, 0, "brk_b1");
    add(0, 0, 0, "brk_b2");
    add(0, 1, 0, "brk_b3");
    add(0, 1, 0, "brk_b4");
    add(0, 0, 0, "brk_b5");
    add(0, 0, 0, "brk_b6");
    // mid-pattern reset: 101, rst, 0 (no detect), then 1010
    add(0, 1, 0, "mrst_b1");
    add(0, 0, 0, "mrst_b2");
    add(0, 1, 0, "mrst_b3");
    add(1, 0, 0, "mrst_reset");
    add(0, 0, 0, "mrst_zero_after");
    add(0, 1, 0, "mrst_re_b1");
    add(0, 0, 0, "mrst_re_b2");
    add(0, 1, 0, "mrst_re_b3");
    add(0, 0, 1, "mrst_re_detect");
    // reset on the edge where z would otherwise stay high / move on
    add(0, 1, 0, "rz_b1");
    add(0, 0, 0, "rz_b2");
    add(0, 1, 0, "rz_b3");
    add(0, 0, 1, "rz_detect");
    add(1, 1, 0, "rz_reset_clears_z");
    add(0, 0, 0, "rz_idle");
    // long runs and DETECT -> S1 restart
    add(0, 1, 0, "run1_a");
    add(0, 1, 0, "run1_b");
    add(0, 1, 0, "run1_c");
    add(0, 0, 0, "run_s2");
    add(0, 0, 0, "run0_a");
    add(0, 0, 0, "run0_b");
    add(0, 1, 0, "run_p_b1");
    add(0, 0, 0, "run_p_b2");
    add(0, 1, 0, "run_p_b3");
    add(0, 0, 1, "run_p_detect");
    add(0, 1, 0, "s4_x1_to_s1");
    add(0, 0, 0, "s4r_b2");
    add(0, 1, 0, "s4r_b3");
    add(0, 0, 1, "s4r_detect");

    // Phase 1: absolute-time stream. The first edge is at 5 ns, with rst high.
    exp_q.push_back(1'b0);
    #6;
    check("reset_state");
    #6;
    rst = 1'b0;  // release at t = 12 ns
    exp_q.push_back(1'b0);
    @(posedge clk);  // 15 ns
    #1;
    check("reset_release");
    #3;
    ts = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 12; i++) begin
      x = ts[i];  // set 4 ns after the previous edge
      exp_q.push_back((i == 3) || (i == 7));  // z high during 55-65 ns and 95-105 ns
      @(posedge clk);
      #1;
      check($sformatf("timed_bit%0d", i + 1));
      #3;
    end

    // Phase 2: table-driven directed vectors.
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].r, vecs[i].xv, vecs[i].ez, vecs[i].name);

    // Phase 3: random stream. The model detects when the last four bits since
    // the last reset or detection read 1010.
    apply(1'b1, 1'b0, 1'b0, "rand_reset");
    hist = '0;
    cnt  = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      xv = 1'($urandom_range(0, 1));
      if (r) begin
        cnt = 0;
        ez  = 1'b0;
      end else begin
        hist = {hist[2:0], xv};
        cnt  = (cnt < 4) ? cnt + 1 : 4;
        if (cnt == 4 && hist == 4'b1010) begin
          ez  = 1'b1;
          cnt = 0;
        end else begin
          ez = 1'b0;
        end
      end
      apply(r, xv, ez, $sformatf("rand_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_1010.md
Name: seq_1010

Overview:
- Moore-type serial sequence detector for the bit pattern 1-0-1-0 on a single-bit input stream, non-overlapping.
- Samples one input bit per rising clock edge. Asserts a one-cycle, state-decoded detect flag after the fourth bit of a complete pattern.
- Standalone leaf block for serial-protocol framing and pattern-spotting logic.

Parameters:
- None. The pattern 1010 and the non-overlapping rule are fixed.

Ports:
- clk  input  1  System clock; all state changes on the rising edge.
- rst  input  1  Reset, synchronous to clk and active-high. Forces the idle state.
- x    input  1  Serial data bit, sampled on each rising clk edge.
- z    output 1  Detect flag. High for exactly one clock period when the state is DETECT.

Behaviour:
- Clocking and reset:
  - One clock, rising-edge only. Reset is synchronous and active-high.
  - While rst=1 at a rising edge: next state = S0 and x is ignored.
  - z=0 from the first reset edge onward. Before the first reset edge the state is undefined.
- State encoding: 3-bit state register with five states. Encoding is free, but no illegal-state lockup is allowed: any unused code goes to S0 on the next edge.
  - S0 = idle / nothing matched
  - S1 = "1" matched
  - S2 = "10" matched
  - S3 = "101" matched
  - S4 = DETECT, "1010" complete
- Transitions (x sampled at the rising edge):
  - S0: x=1 -> S1; x=0 -> S0
  - S1: x=0 -> S2; x=1 -> S1
  - S2: x=1 -> S3; x=0 -> S0
  - S3: x=0 -> S4; x=1 -> S1
  - S4: x=1 -> S1; x=0 -> S0
- Non-overlapping rule: after a detection, none of the matched bits are reused. In particular, S4 on x=1 goes to S1, not S3.
- Output (pure Moore): z = 1 if and only if state == S4. z is decoded from the registered state only, with no combinational path from x to z.
- Latency: the final '0' is sampled at edge N; z rises just after edge N and falls just after edge N+1 (one full cycle).
- Back-to-back patterns: "10101010" produces two detections, after bits 4 and 8, never after bit 6.
- Reset mid-pattern: partial progress is discarded. A pattern must then be fully re-entered after rst deasserts.
- Reset while z=1: z goes to 0 at that edge.
- Long runs: repeated 1s hold S1; repeated 0s from S0/S2/S4 return to or hold S0.

Test Plan:
- Reset: assert rst for at least one edge with x=0, then deassert -> z=0 throughout, state S0.
- Single pattern: after reset, drive x = 1,0,1,0 on four consecutive edges -> z=1 for exactly the cycle following the 4th edge, then 0.
- Non-overlap check: drive x = 1,0,1,0,1,0,1,0 (one bit per edge) -> z pulses exactly twice, after bits 4 and 8; z stays 0 after bit 6.
- Broken pattern: drive x = 1,0,1,1,0,0 -> z stays 0. Bit 4 '1' goes to S1, bit 5 '0' goes to S2, bit 6 '0' goes to S0.
- Mixed timing stream: release reset at t=12 ns (10 ns clock, first edge at 5 ns). Change x 4 ns after each edge to 1,0,1,0,1,0,1,0,1,1,0,0 -> z=1 only during 55–65 ns and 95–105 ns.
- Mid-pattern reset: drive 1,0,1, pulse rst for one edge, then 0 -> z stays 0. Then 1,0,1,0 -> one z pulse.
